qr_mgs_seq: RTL and testbench
=============================

QR_MGS_SEQ -- requirements
Module: qr_mgs_seq

Interface
REQ-001 SHALL have parameter N, default 4, meaning matrix dimension (legal 2..4).
REQ-002 SHALL have parameter W, default 16, meaning signed two's-complement element width.
REQ-003 SHALL have parameter FRAC, default 8, meaning fractional bits of every element (FRAC < W-1).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port enable  input  1  input valid.
REQ-007 SHALL have port accept_out  output  1  block ready to take a matrix.
REQ-008 SHALL have port H_matrix  input  N*N*W  input matrix, row-major, element (0,0) in MSBs.
REQ-009 SHALL have port ready_out  output  1  output valid.
REQ-010 SHALL have port accept_in  input  1  downstream ready.
REQ-011 SHALL have port Q_matrix  output  N*N*W  orthonormal factor, same packing as H_matrix.
REQ-012 SHALL have port R_matrix  output  N*N*W  upper-triangular factor, same packing.
REQ-013 SHALL have port singular  output  1  a zero-norm column occurred in the current result.

Function
REQ-014 SHALL compute H = Q*R by sequential modified Gram-Schmidt with one shared multiplier-accumulator, one bit-serial square root and one bit-serial divider.
REQ-015 SHALL implement FSM states IDLE, LOAD, NORM, SQRT, RECIP, SCALE, DOT, UPD, DONE.
REQ-016 SHALL assert accept_out only in IDLE; capture H_matrix into the working column registers v[0..N-1] on an edge with enable && accept_out, then go to LOAD.
REQ-017 SHALL, per column k = 0..N-1: NORM, N cycles, sum of v_k[i]^2; SQRT, W cycles, r_kk = sqrt(sum) with FRAC fractional bits; RECIP, W cycles, rc = 2^(2*FRAC)/r_kk; SCALE, N cycles, q_k[i] = (v_k[i]*rc)>>FRAC.
REQ-018 SHALL, for each j = k+1..N-1: DOT, N cycles, r_kj = (q_k . v_j)>>FRAC; UPD, N cycles, v_j[i] -= (r_kj*q_k[i])>>FRAC.
REQ-019 SHALL make latency from the accepting edge to ready_out high exactly L = 1 + N*(2N+2W) + N*N*(N-1) cycles (209 for N=4, W=16; 77 for N=2, W=16).
REQ-020 SHALL use an accumulator of 2W+2 bits, saturate the sum of squares to 2^(2W)-1 before SQRT, and saturate every W-bit result (r_kk, rc, q, r_kj, updated v) to [-2^(W-1), 2^(W-1)-1].
REQ-021 SHALL, when r_kk = 0, force rc = 0, q_k = 0, r_kj = 0 for all j, and set singular; the remaining columns still process.
REQ-022 SHALL write R elements below the diagonal as 0.
REQ-023 SHALL, in DONE, hold ready_out high and Q_matrix, R_matrix, singular stable until an edge with accept_in high, then return to IDLE; outputs keep their values after the handshake until the next result overwrites them.
REQ-024 SHALL ignore enable in every state other than IDLE.
REQ-025 SHALL clear singular at LOAD of each new matrix.

Reset
REQ-026 SHALL, on an edge with reset_n low, in any state including mid-computation, go to IDLE and clear ready_out, singular, Q_matrix, R_matrix, v and all datapath registers to 0; accept_out SHALL be 1 on the first edge after reset_n returns high.

Configuration
REQ-027 SHALL, with macro QR_MGS_ROUND_EN defined, round every >>FRAC shift and the RECIP quotient half-up (add 2^(FRAC-1) before shift; remainder*2 >= divisor increments quotient); without it, SHALL truncate toward negative infinity (shift) and toward zero (divide).

Verification
REQ-028 SHALL be checked: N=4, W=16, FRAC=8, H = 256*I, enable 1 cycle -> ready_out high exactly 209 cycles later, Q = 256*I, R = 256*I, singular = 0.
REQ-029 SHALL be checked: N=4, H = 512*I -> Q = 256*I, R = 512*I, singular = 0.
REQ-030 SHALL be checked: N=2, truncating build, column 0 = (768, 1024), column 1 = 0 -> r00 = 1280, q0 = (153, 204), R column 1 = 0, column 1 of Q = 0, singular = 1, ready_out after 77 cycles.
REQ-031 SHALL be checked: N=4, column 0 all zero, other columns 256*e1, e2, e3 -> Q column 0 = 0, R(0,0) = 0, singular = 1.
REQ-032 SHALL be checked: accept_in held low 10 cycles after ready_out rises, enable pulsed meanwhile -> outputs stable, accept_out 0, pulse ignored; accept_in high -> IDLE next edge, accept_out 1.
REQ-033 SHALL be checked: reset_n low for one edge at cycle 50 of a computation -> next edge ready_out = 0, Q_matrix = R_matrix = 0, accept_out = 1 after release.

Source files
------------

// File: rtl/qr_mgs_seq.sv
// qr_mgs_seq: sequential modified Gram-Schmidt QR factorisation, H = Q*R.
// One shared multiply-accumulate, one bit-serial square root and one bit-serial
// divider are time-multiplexed over every column and every column pair.
// Optional build macro QR_MGS_ROUND_EN: round-half-up on every >>FRAC shift and
// on the reciprocal quotient. When it is undefined, shifts truncate toward -inf
// and the quotient truncates toward zero.
module qr_mgs_seq #(
  parameter int N    = 4,
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic             accept_out,
  input  logic [N*N*W-1:0] H_matrix,
  output logic             ready_out,
  input  logic             accept_in,
  output logic [N*N*W-1:0] Q_matrix,
  output logic [N*N*W-1:0] R_matrix,
  output logic             singular
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(W) + 1;
  localparam int AW = 2*W + 2;

  localparam logic signed [AW-1:0] SMAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
  // Reciprocal dividend 2^(2*FRAC); the high half seeds the divider remainder.
  localparam logic [2*W-1:0] DVD = {{(2*W-1){1'b0}}, 1'b1} << (2*FRAC);
`ifdef QR_MGS_ROUND_EN
  localparam logic signed [AW-1:0] RND = {{(AW-1){1'b0}}, 1'b1} << (FRAC-1);
`endif

  typedef enum logic [3:0] {
    IDLE, LOAD, NORM, SQRT, RECIP, SCALE, DOT, UPD, DONE
  } state_t;

  // v/q are stored as column vectors [col][row]; r and outputs as [row][col].
  typedef logic [N-1:0][N-1:0][W-1:0] mat_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         k_q, k_d, j_q, j_d;
  mat_t                  v_q, v_d, q_q, q_d, r_q, r_d, qo_q, qo_d, ro_q, ro_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [2*W-1:0]        rad_q, rad_d;
  logic [W+1:0]          rem_q, rem_d;
  logic [W-1:0]          root_q, root_d, dq_q, dq_d;
  logic [W-1:0]          rkk_q, rkk_d, rc_q, rc_d;
  logic                  ovf_q, ovf_d, colz_q, colz_d, sing_q, sing_d;

  logic signed [W-1:0]   op_a, op_b;
  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  prod_x;
  logic [IW-1:0]         idx;
  logic                  last_n, last_w, last_k, last_j;

  function automatic logic [W-1:0] sat_f(input logic signed [AW-1:0] x);
    if (x > SMAX)      sat_f = SMAX[W-1:0];
    else if (x < SMIN) sat_f = SMIN[W-1:0];
    else               sat_f = x[W-1:0];
  endfunction

  function automatic logic signed [AW-1:0] shr_f(input logic signed [AW-1:0] x);
`ifdef QR_MGS_ROUND_EN
    shr_f = (x + RND) >>> FRAC;
`else
    shr_f = x >>> FRAC;
`endif
  endfunction

  assign idx        = cnt_q[IW-1:0];
  assign last_n     = (cnt_q == CW'(N-1));
  assign last_w     = (cnt_q == CW'(W-1));
  assign last_k     = (k_q == IW'(N-1));
  assign last_j     = (j_q == IW'(N-1));
  assign accept_out = (state_q == IDLE);
  assign ready_out  = (state_q == DONE);
  assign singular   = sing_q;
  assign prod       = op_a * op_b;
  assign prod_x     = {{2{prod[2*W-1]}}, prod};

  genvar gr, gc;
  generate
    for (gr = 0; gr < N; gr++) begin : g_row
      for (gc = 0; gc < N; gc++) begin : g_col
        assign Q_matrix[(N*N-1-(gr*N+gc))*W +: W] = qo_q[gr][gc];
        assign R_matrix[(N*N-1-(gr*N+gc))*W +: W] = ro_q[gr][gc];
      end
    end
  endgenerate

  // Shared multiplier operand select for the active phase.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state_q)
      NORM:    begin op_a = v_q[k_q][idx]; op_b = v_q[k_q][idx]; end
      SCALE:   begin op_a = v_q[k_q][idx]; op_b = rc_q;          end
      DOT:     begin op_a = q_q[k_q][idx]; op_b = v_q[j_q][idx]; end
      UPD:     begin op_a = r_q[k_q][j_q]; op_b = q_q[k_q][idx]; end
      default: ;
    endcase
  end

  // FSM next state and sequencing counters (cycle, column k, pair column j).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    k_d     = k_q;
    j_d     = j_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = '0;
        k_d     = '0;
        state_d = NORM;
      end
      NORM:  if (last_n) begin cnt_d = '0; state_d = SQRT;  end
      SQRT:  if (last_w) begin cnt_d = '0; state_d = RECIP; end
      RECIP: if (last_w) begin cnt_d = '0; state_d = SCALE; end
      SCALE: if (last_n) begin
        cnt_d = '0;
        if (last_k) state_d = DONE;
        else begin
          j_d     = k_q + IW'(1);
          state_d = DOT;
        end
      end
      DOT:   if (last_n) begin cnt_d = '0; state_d = UPD; end
      UPD:   if (last_n) begin
        cnt_d = '0;
        if (last_j) begin
          k_d     = k_q + IW'(1);
          state_d = NORM;
        end else begin
          j_d     = j_q + IW'(1);
          state_d = DOT;
        end
      end
      DONE: begin
        cnt_d = '0;
        if (accept_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next state: MAC phases, bit-serial sqrt/divide, result writeback.
  logic signed [AW-1:0] sum, vext;
  logic [W+1:0]         rem_sh, trial, rem_nx;
  logic [W-1:0]         root_nx, rkk_val;
  logic [W:0]           qw;
  logic                 ge;
  always_comb begin
    v_d = v_q;  q_d = q_q;  r_d = r_q;  qo_d = qo_q;  ro_d = ro_q;
    acc_d = acc_q;  rad_d = rad_q;  rem_d = rem_q;  root_d = root_q;
    dq_d = dq_q;  rkk_d = rkk_q;  rc_d = rc_q;  ovf_d = ovf_q;
    colz_d = colz_q;  sing_d = sing_q;
    sum = acc_q + prod_x;
    vext = '0;  rem_sh = '0;  trial = '0;  rem_nx = '0;  ge = 1'b0;
    root_nx = '0;  rkk_val = '0;  qw = '0;
    case (state_q)
      IDLE: if (enable) begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            v_d[c][r] = H_matrix[(N*N-1-(r*N+c))*W +: W];
      end
      LOAD: begin
        q_d = '0;  r_d = '0;  acc_d = '0;
        sing_d = 1'b0;  colz_d = 1'b0;
      end
      NORM: begin
        if (last_n) begin
          acc_d  = '0;
          rad_d  = (|sum[AW-1:2*W]) ? '1 : sum[2*W-1:0];
          rem_d  = '0;
          root_d = '0;
        end else acc_d = sum;
      end
      SQRT: begin
        // Two radicand bits per cycle, one root bit per cycle.
        rem_sh  = (rem_q << 2) | {{W{1'b0}}, rad_q[2*W-1 -: 2]};
        trial   = {root_q, 2'b01};
        ge      = (rem_sh >= trial);
        rem_nx  = ge ? rem_sh - trial : rem_sh;
        root_nx = {root_q[W-2:0], ge};
        rem_d   = rem_nx;
        root_d  = root_nx;
        rad_d   = rad_q << 2;
        if (last_w) begin
          rkk_val         = root_nx[W-1] ? SMAX[W-1:0] : root_nx;
          rkk_d           = rkk_val;
          r_d[k_q][k_q]   = rkk_val;
          colz_d          = (root_nx == '0);
          if (root_nx == '0) sing_d = 1'b1;
          // Seed the divider; a quotient too wide for W bits saturates.
          rem_d  = {2'b00, DVD[2*W-1:W]};
          root_d = '0;
          dq_d   = DVD[W-1:0];
          ovf_d  = (DVD[2*W-1:W] >= rkk_val);
        end
      end
      RECIP: begin
        // Restoring division, one quotient bit per cycle.
        rem_sh  = (rem_q << 1) | {{(W+1){1'b0}}, dq_q[W-1]};
        trial   = {2'b00, rkk_q};
        ge      = (rem_sh >= trial);
        rem_nx  = ge ? rem_sh - trial : rem_sh;
        root_nx = {root_q[W-2:0], ge};
        rem_d   = rem_nx;
        root_d  = root_nx;
        dq_d    = dq_q << 1;
        if (last_w) begin
          qw = {1'b0, root_nx};
`ifdef QR_MGS_ROUND_EN
          if ({rem_nx, 1'b0} >= {3'b000, rkk_q}) qw = qw + (W+1)'(1);
`endif
          if (colz_q)                        rc_d = '0;
          else if (ovf_q || qw[W] || qw[W-1]) rc_d = SMAX[W-1:0];
          else                               rc_d = qw[W-1:0];
        end
      end
      SCALE: begin
        q_d[k_q][idx] = colz_q ? '0 : sat_f(shr_f(prod_x));
        // Final column: publish the whole result at once.
        if (last_n && last_k) begin
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
              qo_d[r][c] = q_d[c][r];
          ro_d = r_d;
        end
      end
      DOT: begin
        if (last_n) begin
          r_d[k_q][j_q] = colz_q ? '0 : sat_f(shr_f(sum));
          acc_d         = '0;
        end else acc_d = sum;
      end
      UPD: begin
        vext = {{(AW-W){v_q[j_q][idx][W-1]}}, v_q[j_q][idx]};
        v_d[j_q][idx] = sat_f(vext - shr_f(prod_x));
      end
      default: ;
    endcase
  end

  // State and datapath registers; synchronous active-low reset clears all.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;  k_q <= '0;  j_q <= '0;
      v_q     <= '0;  q_q <= '0;  r_q <= '0;  qo_q <= '0;  ro_q <= '0;
      acc_q   <= '0;  rad_q <= '0;  rem_q <= '0;  root_q <= '0;  dq_q <= '0;
      rkk_q   <= '0;  rc_q <= '0;  ovf_q <= 1'b0;  colz_q <= 1'b0;
      sing_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;  k_q <= k_d;  j_q <= j_d;
      v_q     <= v_d;  q_q <= q_d;  r_q <= r_d;  qo_q <= qo_d;  ro_q <= ro_d;
      acc_q   <= acc_d;  rad_q <= rad_d;  rem_q <= rem_d;  root_q <= root_d;
      dq_q    <= dq_d;  rkk_q <= rkk_d;  rc_q <= rc_d;  ovf_q <= ovf_d;
      colz_q  <= colz_d;  sing_q <= sing_d;
    end
  end

endmodule

// File: tb/tb_qr_mgs_seq.sv
// tb_qr_mgs_seq: scoreboard bench for qr_mgs_seq (N=4 and N=2 instances).
module tb_qr_mgs_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en4, acc4, rdy4, ain4, s4;
  logic [255:0] h4, q4, r4;
  logic         en2, acc2, rdy2, ain2, s2;
  logic [63:0]  h2, q2, r2;

  typedef struct {
    logic [255:0] q;
    logic [255:0] r;
    logic         s;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  qr_mgs_seq #(.N(4), .W(16), .FRAC(8)) u_dut4 (
    .clk(clk), .reset_n(rst_n), .enable(en4), .accept_out(acc4),
    .H_matrix(h4), .ready_out(rdy4), .accept_in(ain4),
    .Q_matrix(q4), .R_matrix(r4), .singular(s4));

  qr_mgs_seq #(.N(2), .W(16), .FRAC(8)) u_dut2 (
    .clk(clk), .reset_n(rst_n), .enable(en2), .accept_out(acc2),
    .H_matrix(h2), .ready_out(rdy2), .accept_in(ain2),
    .Q_matrix(q2), .R_matrix(r2), .singular(s2));

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] put4(input logic [255:0] m, input int r, input int c, input int val);
    logic [15:0] e;
    e = 16'(val);
    m[(15-(r*4+c))*16 +: 16] = e;
    return m;
  endfunction

  function automatic logic [255:0] dg4(input int a0, input int a1, input int a2, input int a3);
    logic [255:0] m;
    m = '0;
    m = put4(m, 0, 0, a0);
    m = put4(m, 1, 1, a1);
    m = put4(m, 2, 2, a2);
    m = put4(m, 3, 3, a3);
    return m;
  endfunction

  function automatic logic [63:0] put2(input logic [63:0] m, input int r, input int c, input int val);
    logic [15:0] e;
    e = 16'(val);
    m[(3-(r*2+c))*16 +: 16] = e;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input bit two, input logic [255:0] h);
    tick();
    chk(two ? "acc2_pre" : "acc4_pre", two ? acc2 : acc4, 1);
    if (two) begin h2 = h[63:0]; en2 = 1'b1; end
    else     begin h4 = h;       en4 = 1'b1; end
    tick();
    en2 = 1'b0;
    en4 = 1'b0;
  endtask

  // Waits for ready_out, then pops the oldest expectation and compares.
  task automatic collect(input bit two, output exp_t e);
    int cyc;
    cyc = 0;
    while (!(two ? rdy2 : rdy4) && cyc < 1000) begin
      tick();
      cyc++;
    end
    chk("rdy_timeout", two ? rdy2 : rdy4, 1);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
      e = '{q: '0, r: '0, s: 1'b0, lat: 0};
    end else begin
      e = sb.pop_front();
      chk("lat", cyc, e.lat);
      chk("Q", two ? {192'b0, q2} : q4, e.q);
      chk("R", two ? {192'b0, r2} : r4, e.r);
      chk("sing", two ? s2 : s4, e.s);
    end
  endtask

  task automatic handshake(input bit two);
    if (two) ain2 = 1'b1; else ain4 = 1'b1;
    tick();
    ain2 = 1'b0;
    ain4 = 1'b0;
    chk("rdy_after_hs", two ? rdy2 : rdy4, 0);
    chk("acc_after_hs", two ? acc2 : acc4, 1);
  endtask

  task automatic run_case(input bit two, input logic [255:0] h, input exp_t e, input bit hold);
    exp_t got_e;
    sb.push_back(e);
    start(two, h);
    collect(two, got_e);
    if (!hold) handshake(two);
    else begin
      // Downstream stalls; an enable pulse in DONE must be ignored.
      for (int c = 0; c < 10; c++) begin
        if (c == 3) begin h4 = dg4(7, 7, 7, 7); en4 = 1'b1; end
        tick();
        en4 = 1'b0;
        chk("hold_rdy", rdy4, 1);
        chk("hold_acc", acc4, 0);
        chk("hold_Q", q4, got_e.q);
        chk("hold_R", r4, got_e.r);
      end
      handshake(1'b0);
      chk("keep_Q", q4, got_e.q);
      chk("keep_R", r4, got_e.r);
      tick();
      chk("idle_acc", acc4, 1);
    end
  endtask

  initial begin
    exp_t e;
    logic [255:0] h;
    logic [63:0]  m2;
    rst_n = 1'b0;
    en4 = 1'b0; ain4 = 1'b0; h4 = '0;
    en2 = 1'b0; ain2 = 1'b0; h2 = '0;
    repeat (3) tick();
    chk("rst_rdy", rdy4, 0);
    chk("rst_Q", q4, 0);
    chk("rst_R", r4, 0);
    chk("rst_sing", s4, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_acc", acc4, 1);

    // Identity scaled by 256, with stall/hold check.
    e = '{q: dg4(256, 256, 256, 256), r: dg4(256, 256, 256, 256), s: 1'b0, lat: 209};
    run_case(1'b0, dg4(256, 256, 256, 256), e, 1'b1);

    // 512*I.
    e = '{q: dg4(256, 256, 256, 256), r: dg4(512, 512, 512, 512), s: 1'b0, lat: 209};
    run_case(1'b0, dg4(512, 512, 512, 512), e, 1'b0);

    // Zero first column.
    e = '{q: dg4(0, 256, 256, 256), r: dg4(0, 256, 256, 256), s: 1'b1, lat: 209};
    run_case(1'b0, dg4(0, 256, 256, 256), e, 1'b0);

    // Mixed-sign diagonal: Q carries the sign, R stays positive.
    e = '{q: dg4(-256, 256, 256, -256), r: dg4(256, 1024, 128, 2048), s: 1'b0, lat: 209};
    run_case(1'b0, dg4(-256, 1024, 128, -2048), e, 1'b0);

    // N=2: column 0 = (768,1024), column 1 zero.
    m2 = '0; m2 = put2(m2, 0, 0, 153); m2 = put2(m2, 1, 0, 204);
    e.q = {192'b0, m2};
    m2 = '0; m2 = put2(m2, 0, 0, 1280);
    e.r = {192'b0, m2};
    e.s = 1'b1;
    e.lat = 77;
    m2 = '0; m2 = put2(m2, 0, 0, 768); m2 = put2(m2, 1, 0, 1024);
    run_case(1'b1, {192'b0, m2}, e, 1'b0);

    // Reset in mid computation.
    start(1'b0, dg4(256, 256, 256, 256));
    repeat (49) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_rdy", rdy4, 0);
    chk("midrst_Q", q4, 0);
    chk("midrst_R", r4, 0);
    rst_n = 1'b1;
    tick();
    chk("midrst_acc", acc4, 1);

    // Off-diagonal projection: column 1 = (256,256,0,0).
    h = dg4(256, 256, 256, 256);
    h = put4(h, 0, 1, 256);
    e.q = dg4(256, 256, 256, 256);
    e.r = put4(dg4(256, 256, 256, 256), 0, 1, 256);
    e.s = 1'b0;
    e.lat = 209;
    run_case(1'b0, h, e, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
